// File: rtl/systolic_drain_if.sv
// Result-memory write port of the systolic array drain.
//   wr_en    : write request valid (driven by the drain)
//   wr_addr  : row-major tile address, row*N2 + column
//   wr_data  : result value
//   wr_ready : memory accepts the write this cycle
// The master modport is the drain side; the slave modport is the memory side.
interface systolic_drain_if #(
  parameter int unsigned D_W_ACC = 32,
  parameter int unsigned ADDR_W  = 5
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [D_W_ACC-1:0] wr_data;
  logic               wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/systolic_drain.sv
// Output collector for the systolic array. Captures each row's results as they
// shift out of the last column, buffers them in per-row FIFOs and serialises them
// through a round-robin arbiter onto one valid/ready write port, tagging each
// result with its row-major address in the N1 x N2 tile.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse, arms for a new tile and flushes all state
//   D         : row i result at [i*D_W_ACC +: D_W_ACC]
//   valid_D   : per-row result valid
//   wr        : write port (wr_en/wr_addr/wr_data out, wr_ready in)
//   busy      : armed and tile not yet fully written
//   done      : one-cycle pulse after the last write of the tile is accepted
//   overflow  : sticky drop flag, cleared by start or rst
module systolic_drain #(
  parameter int unsigned D_W_ACC    = 32,
  parameter int unsigned N1         = 8,
  parameter int unsigned N2         = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N1*D_W_ACC-1:0] D,
  input  logic [N1-1:0]         valid_D,
  systolic_drain_if.master      wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned Total = N1 * N2;
  localparam int unsigned AddrW = $clog2(Total);
  localparam int unsigned ColW  = (N2 > 1) ? $clog2(N2) : 1;
  localparam int unsigned KW    = $clog2(N2 + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned RowW  = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned TotW  = $clog2(Total + 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e state_q, state_d;

  // Per-row arrival counters; saturate at N2.
  logic [KW-1:0]      k_q  [N1];
  logic [KW-1:0]      k_d  [N1];
  // FIFO pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]      rd_q [N1];
  logic [PtrW:0]      rd_d [N1];
  logic [PtrW:0]      wp_q [N1];
  logic [PtrW:0]      wp_d [N1];
  logic [D_W_ACC-1:0] mem_data_q [N1][FIFO_DEPTH];
  logic [ColW-1:0]    mem_col_q  [N1][FIFO_DEPTH];

  logic [N1-1:0]      empty, full, push, pop;
  logic [ColW-1:0]    push_col [N1];

  logic [TotW-1:0]    total_q, total_d;
  logic [RowW-1:0]    rr_q, rr_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [D_W_ACC-1:0] data_q, data_d;

  logic               accept;
  logic               found;
  int                 gnt;
  int                 scan;

  always_comb begin
    for (int i = 0; i < int'(N1); i++) begin
      empty[i] = (rd_q[i] == wp_q[i]);
      full[i]  = (rd_q[i][PtrW] != wp_q[i][PtrW]) &&
                 (rd_q[i][PtrW-1:0] == wp_q[i][PtrW-1:0]);
      // The PE in column N2-1 drains first, so columns arrive in reverse order.
      push_col[i] = ColW'(int'(N2) - 1 - int'(k_q[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rd_d    = rd_q;
    wp_d    = wp_q;
    total_d = total_q;
    rr_d    = rr_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    push    = '0;
    pop     = '0;
    found   = 1'b0;
    gnt     = 0;
    scan    = 0;
    accept  = wr_en_q && wr.wr_ready;

    if (start) begin
      // Abort/arm wins over everything else this cycle.
      state_d = StCollect;
      total_d = '0;
      rr_d    = '0;
      ovf_d   = 1'b0;
      wr_en_d = 1'b0;
      for (int i = 0; i < int'(N1); i++) begin
        k_d[i]  = '0;
        rd_d[i] = '0;
        wp_d[i] = '0;
      end
    end else if (state_q == StCollect) begin
      if (accept) begin
        total_d = total_q + 1'b1;
        if (total_q == TotW'(Total - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      // Output register is free or being emptied: grant one row.
      if (!wr_en_q || accept) begin
        wr_en_d = 1'b0;
        for (int off = 0; off < int'(N1); off++) begin
          scan = (int'(rr_q) + off) % int'(N1);
          if (!found && !empty[scan]) begin
            found = 1'b1;
            gnt   = scan;
          end
        end
        if (found) begin
          pop[gnt]  = 1'b1;
          rd_d[gnt] = rd_q[gnt] + 1'b1;
          wr_en_d   = 1'b1;
          addr_d    = AddrW'(gnt * int'(N2) + int'(mem_col_q[gnt][rd_q[gnt][PtrW-1:0]]));
          data_d    = mem_data_q[gnt][rd_q[gnt][PtrW-1:0]];
          rr_d      = RowW'((gnt + 1) % int'(N1));
        end
      end

      for (int i = 0; i < int'(N1); i++) begin
        if (valid_D[i]) begin
          if (k_q[i] == KW'(N2)) begin
            ovf_d = 1'b1;
          end else begin
            // k still advances on a full-FIFO drop so later addresses stay right.
            k_d[i] = k_q[i] + 1'b1;
            if (full[i] && !pop[i]) begin
              ovf_d = 1'b1;
            end else begin
              push[i] = 1'b1;
              wp_d[i] = wp_q[i] + 1'b1;
            end
          end
        end
      end
    end else begin
      if (|valid_D) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      total_q <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < int'(N1); i++) begin
        k_q[i]  <= '0;
        rd_q[i] <= '0;
        wp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      for (int i = 0; i < int'(N1); i++) begin
        k_q[i]  <= k_d[i];
        rd_q[i] <= rd_d[i];
        wp_q[i] <= wp_d[i];
      end
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N1); i++) begin
      if (push[i]) begin
        mem_data_q[i][wp_q[i][PtrW-1:0]] <= D[i*D_W_ACC +: D_W_ACC];
        mem_col_q[i][wp_q[i][PtrW-1:0]]  <= push_col[i];
      end
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign busy       = (state_q == StCollect);
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output collector that sits directly downstream of the systolic array in the ece327_mm matrix-multiply datapath. It captures each row's accumulated results as they shift out of the array's last column (`D` / `valid_D`), buffers them in small per-row FIFOs, and serialises them through a round-robin arbiter onto a single valid/ready write port into the result memory. Each result is tagged with its row-major address in the N1×N2 output tile. The block signals completion when the whole tile has been written.

## Interface
- `D_W_ACC`, 32, accumulator/result width (matches array)
- `N1`, 8, array rows
- `N2`, 4, array columns = results per row per tile
- `FIFO_DEPTH`, 4, entries per row FIFO (power of two, ≥2)
- `clk` in 1, single clock; all state on rising edge
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, one-cycle pulse: arm for a new tile, flush all state
- `D` in N1*D_W_ACC, row i result at `[i*D_W_ACC +: D_W_ACC]`, signed
- `valid_D` in N1, row i result valid this cycle
- `wr_en` out 1, write request valid
- `wr_addr` out $clog2(N1*N2), tile address = row*N2 + column
- `wr_data` out D_W_ACC, result value, passed through bit-exact
- `wr_ready` in 1, memory accepts the write this cycle
- `busy` out 1, armed and tile not yet fully written
- `done` out 1, one-cycle pulse when the last of N1*N2 writes is accepted
- `overflow` out 1, sticky error flag; cleared by `start` or `rst`

## Operation
- States: IDLE, COLLECT. `start` → COLLECT (from either state). Last write accepted → IDLE, `done` pulses.
- On entry to COLLECT, the following are cleared:
  - per-row arrival counters `k_i`
  - all FIFOs
  - total write counter
  - round-robin pointer (row 0 has highest priority first)
  - `overflow`
- Capture, COLLECT only: `valid_D[i]` pushes {D row i, col = N2-1-k_i} into FIFO i, then k_i increments. Column order is reversed because the PE in column N2-1 drains first.
- Drop cases. In each case the sample is discarded and `overflow` is set:
  - k_i == N2: surplus sample; k_i saturates.
  - FIFO i is full and not popped in the same cycle: k_i still increments, so later addresses stay correct.
  - IDLE: any `valid_D` bit.
- Simultaneous push and pop on a full FIFO is legal; no drop.
- Arbiter:
  - Runs when the output register is empty, or is being accepted this cycle (`wr_en && wr_ready`).
  - Grants the first non-empty FIFO at or after the pointer, pops it, and loads the output register.
  - Pointer moves to granted row + 1, wrapping at N1.
  - One grant per cycle maximum.
- Write handshake:
  - `wr_en`/`wr_addr`/`wr_data` come from registers.
  - Once `wr_en` is high, all three hold stable until a cycle with `wr_ready` high.
  - Back-to-back writes are allowed: one per cycle while `wr_ready` stays high.
- Completion: the total-accepted counter reaches N1*N2 → `done` high for one cycle, `busy` falls in the same cycle, state returns to IDLE.
- Abort: `start` during COLLECT takes priority over everything in that cycle:
  - `valid_D` samples in that cycle are discarded and not counted.
  - A pending `wr_en` drops in the next cycle, without waiting for `wr_ready`.
  - No `done` pulse.
- Reset: asynchronous. `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `overflow`=0. State goes to IDLE; FIFOs and counters are cleared.

## Timing
- Capture latency: `valid_D[i]` in cycle t → FIFO entry after edge t → grant in cycle t+1 → `wr_en` high in cycle t+2. Minimum latency is 2 cycles.
- Throughput: one write per cycle. N1 simultaneous arrivals drain over N1 consecutive cycles when `wr_ready` is held high.
- `busy` rises the cycle after `start` is sampled.
- `done` coincides with the cycle after the final accepted handshake edge. `busy` is low in that same cycle.
- `overflow` asserts the cycle after the offending sample.

## Test plan
- **Single row:** after `start`, `valid_D`=8'h01 for 4 cycles with D row 0 = 10, 11, 12, 13, `wr_ready`=1 → writes (3,10), (2,11), (1,12), (0,13). First write 2 cycles after first valid.
- **Full tile, all rows together:** `valid_D`=8'hFF for 4 cycles with row i, column c value = 100*i + c, `wr_ready`=1 → 32 writes in round-robin row order, addresses i*4+c with matching data. `done` pulses once, then `busy`=0.
- **Backpressure:** same tile with `wr_ready` toggling 1,0,1,0 → `wr_en`/addr/data stable across ready-low cycles. No data lost, `overflow`=0, 32 writes total.
- **FIFO overflow:** `wr_ready`=0; row 2 valid for 5 cycles (FIFO_DEPTH=4, N2=4) → `overflow`=1. After `wr_ready`=1, exactly the 4 FIFO entries are written, with addresses 11, 10, 9, 8.
- **Abort and reset:**
  - `start` re-pulsed mid-tile with a write pending → `wr_en` low next cycle, `overflow` cleared, next tile starts at k_i=0, and no `done` pulse is issued for the aborted tile.
  - `rst` asserted mid-tile → all outputs 0 immediately, without waiting for a clock edge.
